// File: rtl/wave_gen_if.sv
// Bus between the function-generator control path and the waveform sample generator.
// The master drives divider count and button pulse; the slave returns phase and samples.
interface wave_gen_if #(
    parameter int W = 8
);
    logic [2:0]   tick_in;
    logic         wave_btn;
    logic [W-1:0] phase;
    logic [1:0]   wave_cur;
    logic [W-1:0] sample_out;
    logic         sample_vld;

    modport master (
        output tick_in,
        output wave_btn,
        input  phase,
        input  wave_cur,
        input  sample_out,
        input  sample_vld
    );

    modport slave (
        input  tick_in,
        input  wave_btn,
        output phase,
        output wave_cur,
        output sample_out,
        output sample_vld
    );
endinterface

// File: rtl/wave_gen.sv
// Waveform sample generator: advances a phase on each divider zero count and emits
// registered saw/square/triangle samples; waveform changes take effect only at phase wrap.
module wave_gen #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst,
    wave_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        WAVE_SAW      = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_NONE     = 2'd3
    } wave_t;

    localparam logic [W-1:0] PHASE_ONE = W'(1);
    localparam logic [W-1:0] PHASE_MAX = '1;

    logic [W-1:0] phase_q;
    logic [1:0]   pend_sel_q;
    wave_t        wave_cur_q;
    logic         step_d_q;
    logic [W-1:0] sample_q;
    logic         sample_vld_q;

    logic         step;
    logic         wrap;
    logic [1:0]   pend_next;
    logic [W-1:0] shaped;

    // Triangle folds the phase: the low W-1 bits doubled rise, then invert to fall.
    function automatic logic [W-1:0] shape(input wave_t w, input logic [W-1:0] p);
        logic [W-1:0] t;
        t = {p[W-2:0], 1'b0};
        case (w)
            WAVE_SAW:      shape = p;
            WAVE_SQUARE:   shape = p[W-1] ? '0 : '1;
            WAVE_TRIANGLE: shape = p[W-1] ? ~t : t;
            default:       shape = '0;
        endcase
    endfunction

    always_comb begin
        step      = (bus.tick_in == 3'd0);
        wrap      = step && (phase_q == PHASE_MAX);
        pend_next = (pend_sel_q == 2'd2) ? 2'd0 : pend_sel_q + 2'd1;
        shaped    = shape(wave_cur_q, phase_q);
    end

    // The sample uses the phase registered on the previous step edge, one cycle behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            pend_sel_q   <= 2'd0;
            wave_cur_q   <= WAVE_SAW;
            step_d_q     <= 1'b0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
        end else begin
            if (step) begin
                phase_q <= phase_q + PHASE_ONE;
            end
            if (wrap) begin
                wave_cur_q <= wave_t'(pend_sel_q);
            end
            if (bus.wave_btn) begin
                pend_sel_q <= pend_next;
            end
            step_d_q <= step;
            if (step_d_q) begin
                sample_q     <= shaped;
                sample_vld_q <= 1'b1;
            end else begin
                sample_vld_q <= 1'b0;
            end
        end
    end

    assign bus.phase      = phase_q;
    assign bus.wave_cur   = wave_cur_q;
    assign bus.sample_out = sample_q;
    assign bus.sample_vld = sample_vld_q;

endmodule

// File: tb/tb_wave_gen.sv
// Directed self-checking bench for wave_gen (W=8): reset, saw, divided rate,
// deferred select, triangle shape, and corner events around wrap and reset.
module tb_wave_gen;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wave_gen_if #(.W(8)) bus ();

    wave_gen #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.tick_in  = 3'd1;
        bus.wave_btn = 1'b0;
        edge_wait();
        rst = 1'b0;
    endtask

    task automatic step_n(input int n);
        bus.tick_in = 3'd0;
        for (int i = 0; i < n; i++) edge_wait();
        bus.tick_in = 3'd1;
    endtask

    task automatic press();
        bus.wave_btn = 1'b1;
        edge_wait();
        bus.wave_btn = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.tick_in  = 3'd0;
        bus.wave_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_wait();
            total++;
            if (bus.phase !== 8'd0 || bus.wave_cur !== 2'd0 ||
                bus.sample_out !== 8'd0 || bus.sample_vld !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset cyc%0d: phase=%0d cur=%0d sample=%0d vld=%0b, want all 0",
                         i, bus.phase, bus.wave_cur, bus.sample_out, bus.sample_vld);
            end
        end
        rst          = 1'b0;
        bus.wave_btn = 1'b0;
    endtask

    // Continuous stepping from reset; the wrap at edge 256 must keep saw since no select was recorded.
    task automatic test_saw();
        logic [7:0] exp_phase;
        logic [7:0] exp_sample;
        bus.tick_in = 3'd0;
        for (int n = 1; n <= 258; n++) begin
            edge_wait();
            exp_phase  = 8'(n);
            exp_sample = 8'(n - 1);
            total++;
            if (bus.phase !== exp_phase || bus.wave_cur !== 2'd0) begin
                bad++;
                $display("[TB] FAIL saw_phase n=%0d: phase=%0d cur=%0d, want phase=%0d cur=0",
                         n, bus.phase, bus.wave_cur, exp_phase);
            end
            total++;
            if (bus.sample_vld !== (n >= 2)) begin
                bad++;
                $display("[TB] FAIL saw_vld n=%0d: vld=%0b, want %0b", n, bus.sample_vld, n >= 2);
            end
            if (n >= 2) begin
                total++;
                if (bus.sample_out !== exp_sample) begin
                    bad++;
                    $display("[TB] FAIL saw_sample n=%0d: sample=%0d, want %0d",
                             n, bus.sample_out, exp_sample);
                end
            end
        end
        bus.tick_in = 3'd1;
    endtask

    task automatic test_divided();
        logic [7:0] exp_phase;
        logic [7:0] exp_sample;
        logic       exp_vld;
        do_reset();
        exp_sample = 8'd0;
        for (int i = 0; i < 12; i++) begin
            bus.tick_in = 3'(i % 3);
            edge_wait();
            exp_phase = 8'(i / 3 + 1);
            exp_vld   = (i >= 1) && ((i - 1) % 3 == 0);
            if (exp_vld) exp_sample = 8'((i - 1) / 3 + 1);
            total++;
            if (bus.phase !== exp_phase || bus.sample_vld !== exp_vld ||
                bus.sample_out !== exp_sample) begin
                bad++;
                $display("[TB] FAIL divided i=%0d: phase=%0d vld=%0b sample=%0d, want %0d %0b %0d",
                         i, bus.phase, bus.sample_vld, bus.sample_out,
                         exp_phase, exp_vld, exp_sample);
            end
        end
        bus.tick_in = 3'd1;
    endtask

    task automatic test_deferred();
        logic [7:0] exp_phase;
        logic [1:0] exp_cur;
        do_reset();
        step_n(100);
        bus.tick_in = 3'd0;
        press();
        for (int e = 102; e <= 385; e++) begin
            edge_wait();
            exp_phase = 8'(e);
            exp_cur   = (e >= 256) ? 2'd1 : 2'd0;
            total++;
            if (bus.phase !== exp_phase || bus.wave_cur !== exp_cur) begin
                bad++;
                $display("[TB] FAIL deferred e=%0d: phase=%0d cur=%0d, want %0d %0d",
                         e, bus.phase, bus.wave_cur, exp_phase, exp_cur);
            end
            if (e == 257 || e == 384 || e == 385) begin
                total++;
                if (bus.sample_out !== ((e == 385) ? 8'h00 : 8'hFF)) begin
                    bad++;
                    $display("[TB] FAIL deferred_square e=%0d: sample=%0h, want %0h",
                             e, bus.sample_out, (e == 385) ? 8'h00 : 8'hFF);
                end
            end
        end
        bus.tick_in = 3'd1;
    endtask

    task automatic test_triangle();
        logic [7:0] exp_sample;
        logic       chk;
        do_reset();
        press();
        press();
        bus.tick_in = 3'd0;
        for (int e = 1; e <= 512; e++) begin
            edge_wait();
            if (e == 256) begin
                total++;
                if (bus.wave_cur !== 2'd2) begin
                    bad++;
                    $display("[TB] FAIL tri_cur: cur=%0d, want 2", bus.wave_cur);
                end
            end
            chk = 1'b1;
            case (e)
                257:     exp_sample = 8'd0;
                321:     exp_sample = 8'd128;
                384:     exp_sample = 8'd254;
                385:     exp_sample = 8'd255;
                512:     exp_sample = 8'd1;
                default: begin
                    chk        = 1'b0;
                    exp_sample = 8'd0;
                end
            endcase
            if (chk) begin
                total++;
                if (bus.sample_out !== exp_sample || bus.sample_vld !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL tri_sample phase=%0d: sample=%0d vld=%0b, want %0d 1",
                             e - 257, bus.sample_out, bus.sample_vld, exp_sample);
                end
            end
        end
        bus.tick_in = 3'd1;
    endtask

    task automatic test_btn_on_wrap();
        do_reset();
        step_n(255);
        bus.tick_in = 3'd0;
        press();
        total++;
        if (bus.phase !== 8'd0 || bus.wave_cur !== 2'd0) begin
            bad++;
            $display("[TB] FAIL wrap_btn_first: phase=%0d cur=%0d, want 0 0", bus.phase, bus.wave_cur);
        end
        for (int e = 257; e <= 513; e++) begin
            edge_wait();
            if (e == 511) begin
                total++;
                if (bus.wave_cur !== 2'd0) begin
                    bad++;
                    $display("[TB] FAIL wrap_btn_hold: cur=%0d, want 0", bus.wave_cur);
                end
            end
            if (e == 512) begin
                total++;
                if (bus.wave_cur !== 2'd1) begin
                    bad++;
                    $display("[TB] FAIL wrap_btn_apply: cur=%0d, want 1", bus.wave_cur);
                end
            end
            if (e == 513) begin
                total++;
                if (bus.sample_out !== 8'hFF) begin
                    bad++;
                    $display("[TB] FAIL wrap_btn_sample: sample=%0h, want ff", bus.sample_out);
                end
            end
        end
        bus.tick_in = 3'd1;
    endtask

    task automatic test_three_presses();
        do_reset();
        press();
        step_n(256);
        total++;
        if (bus.wave_cur !== 2'd1) begin
            bad++;
            $display("[TB] FAIL three_setup: cur=%0d, want 1", bus.wave_cur);
        end
        press();
        press();
        press();
        step_n(256);
        total++;
        if (bus.wave_cur !== 2'd1 || bus.phase !== 8'd0) begin
            bad++;
            $display("[TB] FAIL three_presses: cur=%0d phase=%0d, want 1 0", bus.wave_cur, bus.phase);
        end
        step_n(1);
        total++;
        if (bus.sample_out !== 8'hFF || bus.sample_vld !== 1'b1) begin
            bad++;
            $display("[TB] FAIL three_sample: sample=%0h vld=%0b, want ff 1",
                     bus.sample_out, bus.sample_vld);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press();
        step_n(256);
        step_n(50);
        rst          = 1'b1;
        bus.tick_in  = 3'd0;
        bus.wave_btn = 1'b1;
        edge_wait();
        total++;
        if (bus.phase !== 8'd0 || bus.wave_cur !== 2'd0 ||
            bus.sample_out !== 8'd0 || bus.sample_vld !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid: phase=%0d cur=%0d sample=%0d vld=%0b, want all 0",
                     bus.phase, bus.wave_cur, bus.sample_out, bus.sample_vld);
        end
        rst          = 1'b0;
        bus.wave_btn = 1'b0;
        edge_wait();
        total++;
        if (bus.phase !== 8'd1 || bus.sample_vld !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_resume1: phase=%0d vld=%0b, want 1 0", bus.phase, bus.sample_vld);
        end
        edge_wait();
        total++;
        if (bus.phase !== 8'd2 || bus.sample_vld !== 1'b1 || bus.sample_out !== 8'd1) begin
            bad++;
            $display("[TB] FAIL reset_resume2: phase=%0d vld=%0b sample=%0d, want 2 1 1",
                     bus.phase, bus.sample_vld, bus.sample_out);
        end
        bus.tick_in = 3'd1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.tick_in  = 3'd1;
        bus.wave_btn = 1'b0;
        test_reset();
        test_saw();
        test_divided();
        test_deferred();
        test_triangle();
        test_btn_on_wrap();
        test_three_presses();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
